// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encoding (common with the ALU controller) and the
// execute-stage state encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SRLV = 4'b0101;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_BNE  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative logical right shifter: one bit per step, down-counter flags the
// step that produces the final value.
module alu_shift_iter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] amount,
    output logic [DATA_W-1:0]  shifted,
    output logic               last
);

    logic [DATA_W-1:0]  shreg;
    logic [SHAMT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data;
            cnt   <= amount;
        end else if (step) begin
            shreg <= shreg >> 1;
            cnt   <= cnt - SHAMT_W'(1);
        end
    end

    // Value the register holds after the current step; the top captures it
    // on the step where the count runs out.
    assign shifted = shreg >> 1;
    assign last    = (cnt == SHAMT_W'(1));

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle ops register in one edge, shifts run on the
// iterative shifter while busy_o stalls the pipeline.
module alu_seq_exec
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [3:0]         ctrl_i,
    input  logic [DATA_W-1:0]  src1_i,
    input  logic [DATA_W-1:0]  src2_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [DATA_W-1:0]  result_o,
    output logic               zero_o,
    output logic               overflow_o
);

    state_t             state, state_next;
    logic [DATA_W-1:0]  sum, diff, op_result, shifted;
    logic [SHAMT_W-1:0] shift_amt;
    logic               op_ovf, op_zero, is_shift, multi_cycle;
    logic               accept, load, step, last;

    assign sum  = src1_i + src2_i;
    assign diff = src1_i - src2_i;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        op_result = '0;
        op_ovf    = 1'b0;
        is_shift  = 1'b0;
        shift_amt = shamt_i;
        case (ctrl_i)
            ALU_ADD: begin
                op_result = sum;
                op_ovf    = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                            (sum[DATA_W-1] != src1_i[DATA_W-1]);
            end
            ALU_SUB: begin
                op_result = diff;
                op_ovf    = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                            (diff[DATA_W-1] != src1_i[DATA_W-1]);
            end
            ALU_AND: op_result = src1_i & src2_i;
            ALU_OR:  op_result = src1_i | src2_i;
            // Direct signed compare stays correct when src1-src2 overflows.
            ALU_SLT: op_result = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            ALU_SRLV: begin
                is_shift  = 1'b1;
                shift_amt = src1_i[SHAMT_W-1:0];
                op_result = src2_i;
            end
            ALU_LUI: op_result = src2_i << 16;
            ALU_BNE: op_result = diff;
            ALU_SRL: begin
                is_shift  = 1'b1;
                op_result = src2_i;
            end
            default: op_result = '0;
        endcase
    end

    // BNE inverts the flag so branch logic can test zero_o uniformly.
    assign op_zero     = (ctrl_i == ALU_BNE) ? (op_result != '0) : (op_result == '0);
    assign multi_cycle = is_shift && (shift_amt != '0);
    assign accept      = start_i && (state == ST_IDLE);
    assign busy_o      = (state == ST_SHIFT);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && multi_cycle) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            done_o     <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state  <= state_next;
            done_o <= 1'b0;
            if (accept && !multi_cycle) begin
                result_o   <= op_result;
                zero_o     <= op_zero;
                overflow_o <= op_ovf;
                done_o     <= 1'b1;
            end else if (state == ST_SHIFT && last) begin
                result_o   <= shifted;
                zero_o     <= (shifted == '0);
                overflow_o <= 1'b0;
                done_o     <= 1'b1;
            end
        end
    end

    alu_shift_iter #(
        .DATA_W (DATA_W),
        .SHAMT_W(SHAMT_W)
    ) u_shift (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (load),
        .step   (step),
        .data   (src2_i),
        .amount (shift_amt),
        .shifted(shifted),
        .last   (last)
    );

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq_exec;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [3:0]        ctrl_i;
    logic [DATA_W-1:0] src1_i, src2_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic              busy_o, done_o, zero_o, overflow_o;
    logic [DATA_W-1:0] result_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    alu_seq_exec #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ctrl_i    (ctrl_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .shamt_i   (shamt_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .overflow_o(overflow_o)
    );

    // Reference: lat counts edges after the accepting edge until done_o is
    // visible (0 for single-cycle ops, k for a shift by k>0).
    task automatic model(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] sh,
                         output logic [31:0] r, output logic z, ov, output int lat);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0; ov = 0; lat = 0;
        case (c)
            4'd0: begin r = a + b; s = sa + sb; ov = (s > S_MAX) || (s < S_MIN); end
            4'd1: begin r = a - b; s = sa - sb; ov = (s > S_MAX) || (s < S_MIN); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: begin r = b >> a[4:0]; lat = int'(a[4:0]); end
            4'd6: r = b << 16;
            4'd7: r = a - b;
            4'd8: begin r = b >> sh; lat = int'(sh); end
            default: r = 0;
        endcase
        z = (c == 4'd7) ? (r != 0) : (r == 0);
    endtask

    // Presents one request, then waits (bounded) for done_o.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] sh,
                         output logic [31:0] r, output logic z, ov, output int lat,
                         output bit busy_seen, output bit timed_out);
        ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = 0; busy_seen = 0; timed_out = 0;
        while (1) begin
            if (busy_o) busy_seen = 1;
            if (done_o) break;
            if (lat >= 64) begin timed_out = 1; break; end
            @(posedge clk_i); #1;
            lat++;
        end
        r = result_o; z = zero_o; ov = overflow_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; ctrl_i = '0; src1_i = '0; src2_i = '0; shamt_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        tests_run++;
        if ({busy_o, done_o, result_o, zero_o, overflow_o} !== 36'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h z=%b ov=%b, expected all 0",
                     busy_o, done_o, result_o, zero_o, overflow_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_add_overflow();
        logic [31:0] r, er; logic z, ov, ez, eov; int lat, elat; bit bs, to;
        do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, r, z, ov, lat, bs, to);
        model(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, er, ez, eov, elat);
        tests_run++;
        if (to || {r, z, ov} !== {er, ez, eov} || lat != elat) begin
            tests_failed++;
            $display("FAIL add_overflow: got res=%h z=%b ov=%b lat=%0d to=%b, expected res=%h z=%b ov=%b lat=%0d",
                     r, z, ov, lat, to, er, ez, eov, elat);
        end
        @(posedge clk_i); #1;
        tests_run++;
        if (done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_done_single: got done=%b in second cycle, expected 0", done_o);
        end
    endtask

    task automatic test_srl_busy();
        logic [31:0] er; logic ez, eov; int elat, busy_cnt, done_cnt, done_at;
        model(4'd8, 32'h0, 32'hF000_0000, 5'd4, er, ez, eov, elat);
        ctrl_i = 4'd8; src1_i = 32'h0; src2_i = 32'hF000_0000; shamt_i = 5'd4; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 1; i <= 8; i++) begin
            if (busy_o) busy_cnt++;
            if (i == 2) begin
                // ADD request with different operands while busy: must be dropped.
                ctrl_i = 4'd0; src1_i = 32'h1111_1111; src2_i = 32'h2222_2222; start_i = 1'b1;
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    tests_run++;
                    if ({result_o, zero_o, overflow_o} !== {er, ez, eov}) begin
                        tests_failed++;
                        $display("FAIL srl_result: got res=%h z=%b ov=%b, expected res=%h z=%b ov=%b",
                                 result_o, zero_o, overflow_o, er, ez, eov);
                    end
                end
            end
        end
        tests_run++;
        if (busy_cnt != elat || done_cnt != 1 || done_at != elat) begin
            tests_failed++;
            $display("FAIL srl_timing: got busy_cycles=%0d dones=%0d done_edge=%0d, expected %0d/1/%0d",
                     busy_cnt, done_cnt, done_at, elat, elat);
        end
    endtask

    task automatic test_srlv_zero_amount();
        logic [31:0] r, er; logic z, ov, ez, eov; int lat, elat; bit bs, to;
        do_op(4'd5, 32'h0000_0020, 32'h1234_5678, 5'd9, r, z, ov, lat, bs, to);
        model(4'd5, 32'h0000_0020, 32'h1234_5678, 5'd9, er, ez, eov, elat);
        tests_run++;
        if (to || bs || {r, z, ov} !== {er, ez, eov} || lat != elat) begin
            tests_failed++;
            $display("FAIL srlv_zero_amt: got res=%h z=%b ov=%b lat=%0d busy_seen=%b to=%b, expected res=%h lat=%0d no busy",
                     r, z, ov, lat, bs, to, er, elat);
        end
    endtask

    task automatic test_bne_slt();
        logic [3:0]  cs [3] = '{4'd7, 4'd7, 4'd4};
        logic [31:0] as [3] = '{32'd5, 32'd5, 32'h8000_0000};
        logic [31:0] bs_ [3] = '{32'd5, 32'd6, 32'h0000_0001};
        logic [31:0] r, er; logic z, ov, ez, eov; int lat, elat; bit bs, to;
        for (int i = 0; i < 3; i++) begin
            do_op(cs[i], as[i], bs_[i], 5'd0, r, z, ov, lat, bs, to);
            model(cs[i], as[i], bs_[i], 5'd0, er, ez, eov, elat);
            tests_run++;
            if (to || {r, z, ov} !== {er, ez, eov} || lat != elat) begin
                tests_failed++;
                $display("FAIL bne_slt[%0d]: got res=%h z=%b ov=%b lat=%0d, expected res=%h z=%b ov=%b lat=%0d",
                         i, r, z, ov, lat, er, ez, eov, elat);
            end
        end
    endtask

    task automatic test_reset_midshift();
        logic [31:0] r, er; logic z, ov, ez, eov; int lat, elat, stray; bit bs, to;
        do_op(4'd0, 32'd1, 32'd1, 5'd0, r, z, ov, lat, bs, to);
        ctrl_i = 4'd8; src2_i = 32'hFFFF_FFFF; shamt_i = 5'd31; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        tests_run++;
        if ({busy_o, done_o, result_o, zero_o, overflow_o} !== 36'd0) begin
            tests_failed++;
            $display("FAIL reset_midshift: got busy=%b done=%b res=%h z=%b ov=%b, expected all 0",
                     busy_o, done_o, result_o, zero_o, overflow_o);
        end
        rst_i = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("FAIL reset_abort: got %0d done pulses after reset, expected 0", stray);
        end
        do_op(4'd3, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0, r, z, ov, lat, bs, to);
        model(4'd3, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0, er, ez, eov, elat);
        tests_run++;
        if (to || {r, z, ov} !== {er, ez, eov} || lat != elat) begin
            tests_failed++;
            $display("FAIL or_after_reset: got res=%h z=%b ov=%b lat=%0d, expected res=%h z=%b ov=%b lat=%0d",
                     r, z, ov, lat, er, ez, eov, elat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, er, a, b; logic z, ov, ez, eov; int lat, elat; bit bs, to;
        do_op(4'd6, 32'h0, 32'h0000_ABCD, 5'd0, r, z, ov, lat, bs, to);
        model(4'd6, 32'h0, 32'h0000_ABCD, 5'd0, er, ez, eov, elat);
        tests_run++;
        if (to || {r, z, ov} !== {er, ez, eov} || lat != elat) begin
            tests_failed++;
            $display("FAIL lui: got res=%h z=%b ov=%b lat=%0d, expected res=%h z=%b ov=%b lat=%0d",
                     r, z, ov, lat, er, ez, eov, elat);
        end
        // Issued while done_o from the LUI is still high.
        a = $urandom; b = $urandom;
        do_op(4'd1, a, b, 5'd0, r, z, ov, lat, bs, to);
        model(4'd1, a, b, 5'd0, er, ez, eov, elat);
        tests_run++;
        if (to || {r, z, ov} !== {er, ez, eov} || lat != elat) begin
            tests_failed++;
            $display("FAIL back_to_back: got res=%h z=%b ov=%b lat=%0d, expected res=%h z=%b ov=%b lat=%0d",
                     r, z, ov, lat, er, ez, eov, elat);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, b; logic [3:0] c; logic [4:0] sh;
        logic z, ov, ez, eov; int lat, elat; bit bs, to;
        for (int i = 0; i < 40; i++) begin
            c  = 4'($urandom_range(15));
            a  = $urandom; b = $urandom; sh = 5'($urandom);
            if (i % 4 == 0) a[31:4] = b[31:4];
            do_op(c, a, b, sh, r, z, ov, lat, bs, to);
            model(c, a, b, sh, er, ez, eov, elat);
            tests_run++;
            if (to || {r, z, ov} !== {er, ez, eov} || lat != elat || bs != (elat > 0)) begin
                tests_failed++;
                $display("FAIL random[%0d] ctrl=%h a=%h b=%h sh=%0d: got res=%h z=%b ov=%b lat=%0d busy=%b, expected res=%h z=%b ov=%b lat=%0d",
                         i, c, a, b, sh, r, z, ov, lat, bs, er, ez, eov, elat);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_srl_busy();
        test_srlv_zero_amount();
        test_bne_slt();
        test_reset_midshift();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU controller, plus the two register operands and the shift amount.
- Single-cycle ops (ADD/SUB/AND/OR/SLT/LUI/BNE) complete with 1-cycle registered latency.
- Shifts (SRL/SRLV) run on an iterative 1-bit-per-cycle shifter, so the CPU control must stall on busy_o.
- Results, branch flag and overflow are registered and held until the next completion.

Parameters:
- DATA_W, 32, operand/result width
- SHAMT_W, 5, shift-amount width (log2 DATA_W)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  request; sampled only when idle
- ctrl_i  in  4  ALU control code (encoding below)
- src1_i  in  DATA_W  operand rs
- src2_i  in  DATA_W  operand rt / immediate
- shamt_i  in  SHAMT_W  instruction shift amount (SRL)
- busy_o  out  1  high while an iterative shift is in progress
- done_o  out  1  one-cycle pulse when result_o/zero_o/overflow_o update
- result_o  out  DATA_W  registered result
- zero_o  out  1  registered branch flag
- overflow_o  out  1  registered signed overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset: state IDLE; busy_o=0, done_o=0, result_o=0, zero_o=0, overflow_o=0, shift register/counter=0.
  - Reset mid-shift aborts the operation: no done_o pulse, outputs take reset values on the next edge.
- Codes:
  - 0000 ADD: src1+src2
  - 0001 SUB: src1-src2
  - 0010 AND
  - 0011 OR
  - 0100 SLT: signed src1<src2 -> 1 else 0; correct even when the subtraction overflows
  - 0101 SRLV: src2 >> src1[4:0], logical
  - 0110 LUI: src2<<16
  - 0111 BNE: src1-src2
  - 1000 SRL: src2 >> shamt_i, logical
  - 1001-1111: result 0, 1-cycle
- Arithmetic: modulo 2^DATA_W, no carry out.
  - overflow_o = signed overflow for ADD/SUB only; 0 for all other codes.
- zero_o = (result==0) for every code except 0111, where zero_o = (result!=0). Downstream branch logic therefore uses zero_o uniformly.
- States: IDLE, SHIFT.
  - IDLE, start_i=1, non-shift code, edge N: outputs load computed values; done_o=1 for the cycle after edge N; stay IDLE.
  - IDLE, start_i=1, shift code, amount k, edge N:
    - k=0: behaves as a non-shift op (result=src2, latency 1).
    - k>0: load shreg=src2, cnt=k, busy_o=1, go to SHIFT.
  - SHIFT: each edge shreg>>=1, cnt-=1. On the edge where cnt reaches 0: result_o=shifted value, zero_o/overflow_o update, done_o=1, busy_o=0, go to IDLE.
  - Latency is k cycles from the accepting edge.
- Operands are captured at the accepting edge; input changes during SHIFT have no effect.
- start_i while busy_o=1 is ignored and not queued.
  - start_i in the cycle done_o is high is accepted (state is IDLE), giving back-to-back ops.
- done_o is never high for 2 consecutive cycles from a single request.
- result_o, zero_o and overflow_o hold between completions.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - 4-bit ALU control code localparams (ALU_ADD .. ALU_SRL), shared with the ALU controller.
  - State encoding (ST_IDLE, ST_SHIFT).
- One sub-module, alu_shift_iter: shift register, down-counter, load/step/last outputs.
- Combinational op mux and flag logic stay in the top level.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, start at edge N -> at N+1: result 0x80000000, overflow_o=1, zero_o=0, done_o pulse.
- SRL src2=0xF0000000, shamt_i=4 -> busy_o high for 4 cycles, done at edge N+4, result 0x0F000000; an ADD start during busy is ignored (no extra done_o).
- SRLV src1=0x00000020 (amount 0), src2=0x12345678 -> 1-cycle latency, result 0x12345678, busy_o never high.
- BNE 5 vs 5 -> result 0, zero_o=0; BNE 5 vs 6 -> zero_o=1. SLT 0x80000000 vs 0x00000001 -> result 1.
- SRL amount 31, assert rst_i at cycle 10 -> next edge: all outputs 0, no done_o; a following OR 0xF0F0 | 0x0F0F -> result 0xFFFF, done after 1 cycle.
- LUI src2=0x0000ABCD -> result 0xABCD0000; back-to-back start in the done cycle -> second result one cycle later.
